// File: rtl/step_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// step_tick_gen_pkg
// Shared constants for the LED-sequencer tick source and its button debouncer.
//   DEF_DIV_W        default prescaler / div width
//   DEF_DB_CYCLES    default debounce stability window on the real board clock
//   SIM_DB_CYCLES    short debounce window used in simulation so benches stay fast
//   cnt_width()      counter width for a window of n cycles (never below 1 bit)
// -----------------------------------------------------------------------------
package step_tick_gen_pkg;

   localparam int DEF_DIV_W     = 26;
   localparam int DEF_DB_CYCLES = 1000000;
   localparam int SIM_DB_CYCLES = 4;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/step_tick_gen_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button, debounces it and flags its rising edge.
// Reusable for any board button.
//   clk    system clock
//   rst    asynchronous active-low reset, clears every flop
//   raw    raw asynchronous button input (active-high, may bounce)
//   level  debounced button level
//   rise   one-cycle pulse while the debounced level has just gone high
//          (combinational from flops only, so no path from raw)
// -----------------------------------------------------------------------------
module btn_debounce
   import step_tick_gen_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
)
(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int            CW      = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic          level_next;
   logic          hist_reg;
   logic [CW-1:0] db_cnt_reg;
   logic [CW-1:0] db_cnt_next;

   // The counter measures how long the synced input has disagreed with the
   // debounced level; any agreement restarts the window, so a glitch shorter
   // than DB_CYCLES clocks can never flip the level.
   always_comb begin
      db_cnt_next = '0;
      level_next  = level_reg;
      if (sync2_reg != level_reg) begin
         if (db_cnt_reg == DB_LAST) begin
            level_next = sync2_reg;
         end else begin
            db_cnt_next = db_cnt_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         level_reg  <= 1'b0;
         db_cnt_reg <= '0;
         hist_reg   <= 1'b0;
      end else begin
         sync1_reg  <= raw;
         sync2_reg  <= sync1_reg;
         level_reg  <= level_next;
         db_cnt_reg <= db_cnt_next;
         // Tracked unconditionally so a button already held when the caller
         // starts listening is not mistaken for a fresh press.
         hist_reg   <= level_reg;
      end
   end

   assign level = level_reg;
   assign rise  = level_reg & ~hist_reg;

endmodule

// File: rtl/step_tick_gen.sv
// -----------------------------------------------------------------------------
// step_tick_gen
// Advance-pulse source for the LED sequencer: free-running prescaler in run
// mode, one tick per debounced button press in step mode.
//   clk         system clock
//   rst         asynchronous active-low reset
//   run         1 = prescaler mode, 0 = step mode
//   div         terminal count; run-mode tick period is div+1 clocks
//   step_btn    raw push-button
//   tick        registered one-cycle advance pulse
//   phase       toggles on every tick
//   tick_count  ticks issued, wraps 255 -> 0
// -----------------------------------------------------------------------------
module step_tick_gen
   import step_tick_gen_pkg::*;
#(
   parameter int DIV_W     = DEF_DIV_W,
   parameter int DB_CYCLES = DEF_DB_CYCLES
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   input  logic             step_btn,
   output logic             tick,
   output logic             phase,
   output logic [7:0]       tick_count
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] cnt_next;
   logic             term;
   logic             tick_next;
   logic             tick_reg;
   logic             phase_reg;
   logic [7:0]       count_reg;
   logic             btn_rise;
   logic             btn_level_unused;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (step_btn),
      .level (btn_level_unused),
      .rise  (btn_rise)
   );

   // >= rather than == so that lowering div below the running count ticks on
   // the next edge instead of wrapping through the full counter range.
   always_comb begin
      term      = (cnt_reg >= div);
      cnt_next  = '0;
      tick_next = btn_rise;
      if (run) begin
         tick_next = term;
         if (!term) begin
            cnt_next = cnt_reg + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= '0;
         tick_reg  <= 1'b0;
         phase_reg <= 1'b0;
         count_reg <= '0;
      end else begin
         cnt_reg   <= cnt_next;
         tick_reg  <= tick_next;
         phase_reg <= phase_reg ^ tick_next;
         count_reg <= count_reg + {7'd0, tick_next};
      end
   end

   assign tick       = tick_reg;
   assign phase      = phase_reg;
   assign tick_count = count_reg;

endmodule
